fetch_decode_ctrl: RTL and testbench
====================================

FETCH_DECODE_CTRL -- requirements
Module: fetch_decode_ctrl

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000, the first fetch address after reset.
REQ-002 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-003 SHALL have port reset_n, input, 1, synchronous, active-low reset.
REQ-004 SHALL have port imem_req, output, 1, instruction-fetch request, held until acknowledged.
REQ-005 SHALL have port imem_addr, output, 32, fetch address; bits [1:0] always 00.
REQ-006 SHALL have port imem_ack, input, 1, fetch complete; imem_rdata valid this cycle.
REQ-007 SHALL have port imem_rdata, input, 32, fetched instruction word.
REQ-008 SHALL have port inst_q, output, 32, registered instruction; feeds the immediate builder and the decoder.
REQ-009 SHALL have port imm_fmt, output, 3, registered format: 0 R, 1 I, 2 S, 3 B, 4 U, 5 J.
REQ-010 SHALL have port dec_pc, output, 32, PC of inst_q.
REQ-011 SHALL have port dec_valid, output, 1, inst_q/imm_fmt/dec_pc offered to execute.
REQ-012 SHALL have port dec_ready, input, 1, execute accepts when dec_valid & dec_ready.
REQ-013 SHALL have port redirect_valid, input, 1, branch/jump redirect.
REQ-014 SHALL have port redirect_pc, input, 32, redirect target; bits [1:0] ignored, treated as 00.
REQ-015 SHALL have port illegal, output, 1, sticky invalid-opcode flag (see Configuration).

Function
REQ-016 SHALL implement states IDLE, FETCH, DECODE, ISSUE, HALT.
REQ-017 IDLE: lasts one cycle after reset release, then -> FETCH.
REQ-018 FETCH: imem_req=1, imem_addr=pc; on imem_ack latch inst_q<=imem_rdata, dec_pc<=pc, -> DECODE.
REQ-019 DECODE: one cycle; imm_fmt registered from inst_q[6:2]: 01101/00101 -> U; 11011 -> J; 11000 -> B; 01000 -> S; 11001/00000/00100 -> I; 01100 -> R; -> ISSUE.
REQ-020 Invalid: any other opcode, or inst_q[1:0] != 11.
REQ-021 ISSUE: dec_valid=1, outputs stable until handshake; on dec_valid & dec_ready pc<=pc+4, -> FETCH.
REQ-022 Latency: imem_ack in cycle N -> dec_valid high in cycle N+2; handshake in ISSUE -> imem_req high next cycle.
REQ-023 pc+4 SHALL wrap modulo 2^32 (32'hFFFF_FFFC -> 32'h0000_0000).
REQ-024 Redirect in any state except FETCH-with-request-outstanding: pc<=redirect_pc, dec_valid low next cycle, -> FETCH.
REQ-025 Redirect in FETCH: pc<=redirect_pc and set kill; next imem_ack (including same-cycle ack) discarded, kill cleared, then re-fetch from new pc; imem_addr changes only after the outstanding ack.
REQ-026 Redirect and dec_ready handshake in the same cycle: redirect wins, pc<=redirect_pc (no +4), the offered instruction still counts as accepted.
REQ-027 dec_valid SHALL be 0 in IDLE, FETCH, DECODE, HALT.

Reset
REQ-028 On reset_n=0 at a clock edge: state=IDLE, pc=RESET_PC, kill=0, imem_req=0, imem_addr=RESET_PC, dec_valid=0, inst_q=0, dec_pc=0, imm_fmt=0, illegal=0.
REQ-029 Reset mid-fetch SHALL abandon the outstanding request; an imem_ack arriving during or after reset before the new request SHALL be ignored.

Configuration
REQ-030 Macro FETCH_ILLEGAL_TRAP_EN defined: invalid opcode in DECODE -> HALT, illegal<=1, imm_fmt=0, no issue; HALT exits only on reset or redirect (clears illegal, -> FETCH).
REQ-031 Macro undefined: invalid opcode issued as R (imm_fmt=0); illegal tied 0; HALT unreachable.

Verification
REQ-032 Reset, RESET_PC=0, ack every request with 32'h00500093 (addi), dec_ready=1 -> imm_fmt=1, dec_pc 0,4,8, one issue per 4 cycles.
REQ-033 imem_rdata 32'h000000EF, 32'h00002023, 32'h00000063, 32'h000002B7 -> imm_fmt 5, 2, 3, 4.
REQ-034 dec_ready=0 for 5 cycles in ISSUE -> dec_valid, inst_q, dec_pc held; no imem_req.
REQ-035 redirect_valid with redirect_pc=32'h0000_0103 one cycle before ack of addr 8 -> that data discarded, next imem_addr=32'h0000_0100.
REQ-036 pc=32'hFFFF_FFFC accepted -> next imem_addr=32'h0000_0000.
REQ-037 With FETCH_ILLEGAL_TRAP_EN, imem_rdata=32'hFFFFFFFF -> illegal=1, dec_valid stays 0 until redirect; without it -> dec_valid=1, imm_fmt=0, illegal=0.

Source files
------------

// File: rtl/fetch_decode_ctrl.sv
// Instruction fetch / immediate-format decode / issue controller with one outstanding fetch.
// Optional build macro FETCH_ILLEGAL_TRAP_EN: an invalid opcode halts with a sticky illegal flag.
module fetch_decode_ctrl #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset_n,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [31:0] inst_q,
    output logic [2:0]  imm_fmt,
    output logic [31:0] dec_pc,
    output logic        dec_valid,
    input  logic        dec_ready,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        illegal
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        FETCH  = 3'd1,
        DECODE = 3'd2,
        ISSUE  = 3'd3,
        HALT   = 3'd4
    } state_t;

    localparam logic [31:0] ADDR_MASK = 32'hFFFF_FFFC;
    localparam logic [31:0] PC_RESET  = RESET_PC & ADDR_MASK;

    state_t      state_r, state_s;
    logic [31:0] pc_r, pc_s;
    logic        kill_r, kill_s;
    logic        req_r, req_s;
    logic [31:0] addr_r, addr_s;
    logic        valid_r, valid_s;
    logic [31:0] inst_r, inst_s;
    logic [31:0] dpc_r, dpc_s;
    logic [2:0]  fmt_r, fmt_s;
    logic [31:0] redir_pc_s;
`ifdef FETCH_ILLEGAL_TRAP_EN
    logic        illegal_r, illegal_s;
`endif

    // Immediate format from the major opcode; unknown opcodes fall back to R (0).
    function automatic logic [2:0] decode_fmt(input logic [31:0] inst);
        logic [2:0] fmt;
        fmt = 3'd0;
        if (inst[1:0] == 2'b11) begin
            case (inst[6:2])
                5'b01101, 5'b00101:           fmt = 3'd4;
                5'b11011:                     fmt = 3'd5;
                5'b11000:                     fmt = 3'd3;
                5'b01000:                     fmt = 3'd2;
                5'b11001, 5'b00000, 5'b00100: fmt = 3'd1;
                5'b01100:                     fmt = 3'd0;
                default:                      fmt = 3'd0;
            endcase
        end else begin
            fmt = 3'd0;
        end
        return fmt;
    endfunction

`ifdef FETCH_ILLEGAL_TRAP_EN
    function automatic logic opcode_known(input logic [31:0] inst);
        logic ok;
        ok = 1'b0;
        if (inst[1:0] == 2'b11) begin
            case (inst[6:2])
                5'b01101, 5'b00101, 5'b11011, 5'b11000, 5'b01000,
                5'b11001, 5'b00000, 5'b00100, 5'b01100: ok = 1'b1;
                default:                                ok = 1'b0;
            endcase
        end else begin
            ok = 1'b0;
        end
        return ok;
    endfunction
`endif

    assign redir_pc_s = redirect_pc & ADDR_MASK;

    // Next-state and next-output computation.
    always_comb begin
        state_s = state_r;
        pc_s    = pc_r;
        kill_s  = kill_r;
        inst_s  = inst_r;
        dpc_s   = dpc_r;
        fmt_s   = fmt_r;
`ifdef FETCH_ILLEGAL_TRAP_EN
        illegal_s = illegal_r;
`endif
        case (state_r)
            IDLE: begin
                state_s = FETCH;
                if (redirect_valid) begin
                    pc_s = redir_pc_s;
                end else begin
                    pc_s = pc_r;
                end
            end
            FETCH: begin
                if (imem_ack) begin
                    // A killed (or same-cycle redirected) response is dropped; stay and re-fetch.
                    if (kill_r || redirect_valid) begin
                        kill_s = 1'b0;
                        pc_s   = redirect_valid ? redir_pc_s : pc_r;
                    end else begin
                        inst_s  = imem_rdata;
                        dpc_s   = pc_r;
                        state_s = DECODE;
                    end
                end else if (redirect_valid) begin
                    pc_s   = redir_pc_s;
                    kill_s = 1'b1;
                end else begin
                    kill_s = kill_r;
                end
            end
            DECODE: begin
                fmt_s = decode_fmt(inst_r);
                if (redirect_valid) begin
                    pc_s    = redir_pc_s;
                    state_s = FETCH;
                end
`ifdef FETCH_ILLEGAL_TRAP_EN
                else if (!opcode_known(inst_r)) begin
                    state_s   = HALT;
                    illegal_s = 1'b1;
                end
`endif
                else begin
                    state_s = ISSUE;
                end
            end
            ISSUE: begin
                // Redirect wins over the handshake; the offered instruction still counts as taken.
                if (redirect_valid) begin
                    pc_s    = redir_pc_s;
                    state_s = FETCH;
                end else if (dec_ready) begin
                    pc_s    = pc_r + 32'd4;
                    state_s = FETCH;
                end else begin
                    state_s = ISSUE;
                end
            end
            HALT: begin
                if (redirect_valid) begin
                    pc_s    = redir_pc_s;
                    state_s = FETCH;
`ifdef FETCH_ILLEGAL_TRAP_EN
                    illegal_s = 1'b0;
`endif
                end else begin
                    state_s = HALT;
                end
            end
            default: begin
                state_s = IDLE;
            end
        endcase
        req_s   = (state_s == FETCH);
        valid_s = (state_s == ISSUE);
        // The address of an outstanding request is held until its response arrives.
        addr_s  = (req_s && kill_s) ? addr_r : pc_s;
    end

    // State and registered-output update.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_r <= IDLE;
            pc_r    <= PC_RESET;
            kill_r  <= 1'b0;
            req_r   <= 1'b0;
            addr_r  <= PC_RESET;
            valid_r <= 1'b0;
            inst_r  <= 32'h0000_0000;
            dpc_r   <= 32'h0000_0000;
            fmt_r   <= 3'd0;
        end else begin
            state_r <= state_s;
            pc_r    <= pc_s;
            kill_r  <= kill_s;
            req_r   <= req_s;
            addr_r  <= addr_s;
            valid_r <= valid_s;
            inst_r  <= inst_s;
            dpc_r   <= dpc_s;
            fmt_r   <= fmt_s;
        end
    end

`ifdef FETCH_ILLEGAL_TRAP_EN
    // Sticky illegal-opcode flag.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            illegal_r <= 1'b0;
        end else begin
            illegal_r <= illegal_s;
        end
    end
    assign illegal = illegal_r;
`else
    assign illegal = 1'b0;
`endif

    assign imem_req  = req_r;
    assign imem_addr = addr_r;
    assign dec_valid = valid_r;
    assign inst_q    = inst_r;
    assign dec_pc    = dpc_r;
    assign imm_fmt   = fmt_r;

endmodule

// File: tb/tb_fetch_decode_ctrl.sv
// Self-checking bench for fetch_decode_ctrl: directed steps plus a randomized phase
// checked against a transaction-level model of the fetch/issue stream.
module tb_fetch_decode_ctrl;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic [31:0] inst_q;
    logic [2:0]  imm_fmt;
    logic [31:0] dec_pc;
    logic        dec_valid;
    logic        dec_ready;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        illegal;

    always #5 clk = ~clk;

    fetch_decode_ctrl dut (
        .clk(clk), .reset_n(reset_n),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
        .inst_q(inst_q), .imm_fmt(imm_fmt), .dec_pc(dec_pc), .dec_valid(dec_valid),
        .dec_ready(dec_ready), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .illegal(illegal)
    );

    int checks = 0;
    int errors = 0;

    // model / stimulus state
    logic [31:0] m_pc, exp_pc, exp_inst, force_pc;
    int          cyc, ack_cyc, req_age, cur_lat, fixed_lat, issues, stall_left;
    bit          valid_seen, exp_req_next, exp_valid_next;
    bit          rand_lat, rand_ready, rand_redir, rand_words, force_redir;
    logic [31:0] word_q[$];
    logic [31:0] iss_pc_q[$];
    logic [2:0]  iss_fmt_q[$];
    int          iss_cyc_q[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [2:0] ref_fmt(input logic [31:0] w);
        if (w[1:0] != 2'b11) return 3'd0;
        case (w[6:2])
            5'b01101, 5'b00101:           return 3'd4;
            5'b11011:                     return 3'd5;
            5'b11000:                     return 3'd3;
            5'b01000:                     return 3'd2;
            5'b11001, 5'b00000, 5'b00100: return 3'd1;
            default:                      return 3'd0;
        endcase
    endfunction

    function automatic logic [31:0] gen_word();
        logic [31:0] r;
        logic [4:0]  ops [9];
        ops = '{5'b01101, 5'b00101, 5'b11011, 5'b11000, 5'b01000,
                5'b11001, 5'b00000, 5'b00100, 5'b01100};
        r = $urandom();
`ifndef FETCH_ILLEGAL_TRAP_EN
        if ($urandom_range(0, 5) == 0) return r;
`endif
        return {r[31:7], ops[$urandom_range(0, 8)], 2'b11};
    endfunction

    function automatic logic [31:0] next_word();
        if (word_q.size() > 0) return word_q.pop_front();
        if (rand_words) return gen_word();
        return 32'h0050_0093;
    endfunction

    function automatic int pick_lat();
        return rand_lat ? int'($urandom_range(0, 3)) : fixed_lat;
    endfunction

    task automatic model_init();
        m_pc = 32'h0000_0000;
        req_age = 0;
        cur_lat = pick_lat();
        valid_seen = 1'b0;
        exp_req_next = 1'b0;
        exp_valid_next = 1'b0;
        force_redir = 1'b0;
        stall_left = 0;
        cyc = 0;
        ack_cyc = -100;
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        imem_ack = 1'b0;
        dec_ready = 1'b0;
        redirect_valid = 1'b0;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        model_init();
    endtask

    // One cycle: check outputs against the model, then drive memory/execute/redirect.
    task automatic tick();
        @(negedge clk);
        cyc++;
        imem_ack = 1'b0;
        redirect_valid = 1'b0;
        if (exp_req_next) begin
            chk("req_after_accept", 32'(imem_req), 32'd1);
            chk("valid_drop_after_accept", 32'(dec_valid), 32'd0);
            exp_req_next = 1'b0;
        end
        if (exp_valid_next) begin
            chk("valid_held", 32'(dec_valid), 32'd1);
            exp_valid_next = 1'b0;
        end
        if (dec_valid) begin
            if (!valid_seen) begin
                chk("ack_to_valid_latency", 32'(cyc - ack_cyc), 32'd2);
                valid_seen = 1'b1;
            end
            chk("dec_pc", dec_pc, exp_pc);
            chk("inst_q", inst_q, exp_inst);
            chk("imm_fmt", 32'(imm_fmt), 32'(ref_fmt(exp_inst)));
            chk("illegal_low", 32'(illegal), 32'd0);
            chk("no_req_in_issue", 32'(imem_req), 32'd0);
            if (stall_left > 0) begin
                dec_ready = 1'b0;
                stall_left--;
            end else if (rand_ready) begin
                dec_ready = 1'($urandom_range(0, 1));
            end else begin
                dec_ready = 1'b1;
            end
            if (force_redir) begin
                redirect_valid = 1'b1;
                redirect_pc = force_pc;
                force_redir = 1'b0;
            end else if (rand_redir && $urandom_range(0, 7) == 0) begin
                redirect_valid = 1'b1;
                redirect_pc = $urandom();
            end
            if (dec_ready || redirect_valid) begin
                iss_pc_q.push_back(dec_pc);
                iss_fmt_q.push_back(imm_fmt);
                iss_cyc_q.push_back(cyc);
                issues++;
                m_pc = redirect_valid ? (redirect_pc & 32'hFFFF_FFFC) : (m_pc + 32'd4);
                exp_req_next = 1'b1;
                valid_seen = 1'b0;
            end else begin
                exp_valid_next = 1'b1;
            end
        end else begin
            dec_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b0;
        end
        if (imem_req) begin
            if (req_age == 0) chk("fetch_addr", imem_addr, m_pc);
            if (req_age >= cur_lat) begin
                imem_ack = 1'b1;
                imem_rdata = next_word();
                exp_pc = m_pc;
                exp_inst = imem_rdata;
                ack_cyc = cyc;
                req_age = 0;
                cur_lat = pick_lat();
            end else begin
                req_age++;
            end
        end else begin
            imem_rdata = $urandom();
        end
    endtask

    task automatic run_issues(input int n);
        int target;
        target = issues + n;
        for (int k = 0; k < 20 * n + 40 && issues < target; k++) tick();
        chk("issue_progress", 32'(issues >= target), 32'd1);
    endtask

    task automatic clear_log();
        iss_pc_q.delete();
        iss_fmt_q.delete();
        iss_cyc_q.delete();
    endtask

    initial begin
        issues = 0; fixed_lat = 1;
        rand_lat = 1'b0; rand_ready = 1'b0; rand_redir = 1'b0; rand_words = 1'b0;
        redirect_pc = 32'h0; imem_rdata = 32'h0;

        // Reset values; an ack during reset and the IDLE cycle is ignored.
        reset_n = 1'b0; imem_ack = 1'b1; imem_rdata = 32'h0000_00EF;
        dec_ready = 1'b1; redirect_valid = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_req", 32'(imem_req), 32'd0);
        chk("rst_addr", imem_addr, 32'h0);
        chk("rst_valid", 32'(dec_valid), 32'd0);
        chk("rst_inst", inst_q, 32'h0);
        chk("rst_dec_pc", dec_pc, 32'h0);
        chk("rst_fmt", 32'(imm_fmt), 32'd0);
        chk("rst_illegal", 32'(illegal), 32'd0);
        reset_n = 1'b1;
        @(negedge clk);
        chk("first_req", 32'(imem_req), 32'd1);
        chk("first_addr", imem_addr, 32'h0);
        chk("idle_ack_ignored", inst_q, 32'h0);
        imem_ack = 1'b0;

        // addi stream, one-cycle memory, always ready: dec_pc 0,4,8 every 4 cycles.
        do_reset();
        clear_log();
        run_issues(3);
        chk("addi_pc0", iss_pc_q[0], 32'h0);
        chk("addi_pc1", iss_pc_q[1], 32'h4);
        chk("addi_pc2", iss_pc_q[2], 32'h8);
        chk("addi_fmt", 32'(iss_fmt_q[1]), 32'd1);
        chk("issue_period_a", 32'(iss_cyc_q[1] - iss_cyc_q[0]), 32'd4);
        chk("issue_period_b", 32'(iss_cyc_q[2] - iss_cyc_q[1]), 32'd4);

        // J, S, B, U formats.
        clear_log();
        word_q.push_back(32'h0000_00EF);
        word_q.push_back(32'h0000_2023);
        word_q.push_back(32'h0000_0063);
        word_q.push_back(32'h0000_02B7);
        run_issues(4);
        chk("fmt_j", 32'(iss_fmt_q[0]), 32'd5);
        chk("fmt_s", 32'(iss_fmt_q[1]), 32'd2);
        chk("fmt_b", 32'(iss_fmt_q[2]), 32'd3);
        chk("fmt_u", 32'(iss_fmt_q[3]), 32'd4);

        // Execute stalls five cycles in ISSUE.
        stall_left = 5;
        run_issues(1);

        // Redirect while the fetch of address 8 is outstanding.
        do_reset();
        run_issues(2);
        @(negedge clk);
        chk("kill_pre_req", 32'(imem_req), 32'd1);
        chk("kill_pre_addr", imem_addr, 32'h8);
        dec_ready = 1'b0; redirect_valid = 1'b1; redirect_pc = 32'h0000_0103;
        @(negedge clk);
        chk("kill_addr_held", imem_addr, 32'h8);
        redirect_valid = 1'b0; imem_ack = 1'b1; imem_rdata = 32'h0000_02B7;
        @(negedge clk);
        chk("refetch_req", 32'(imem_req), 32'd1);
        chk("refetch_addr", imem_addr, 32'h0000_0100);
        chk("killed_no_valid", 32'(dec_valid), 32'd0);
        imem_ack = 1'b1; imem_rdata = 32'h0000_00EF;
        @(negedge clk);
        imem_ack = 1'b0;
        @(negedge clk);
        chk("redir_issue_valid", 32'(dec_valid), 32'd1);
        chk("redir_issue_pc", dec_pc, 32'h0000_0100);
        chk("redir_issue_inst", inst_q, 32'h0000_00EF);
        chk("redir_issue_fmt", 32'(imm_fmt), 32'd5);
        // redirect and handshake together: redirect target wins
        dec_ready = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'h0000_0200;
        @(negedge clk);
        dec_ready = 1'b0; redirect_valid = 1'b0;
        chk("redir_hs_valid", 32'(dec_valid), 32'd0);
        chk("redir_hs_addr", imem_addr, 32'h0000_0200);
        // redirect with a same-cycle ack: the data is dropped
        redirect_valid = 1'b1; redirect_pc = 32'h0000_0300; imem_ack = 1'b1; imem_rdata = 32'h0000_2023;
        @(negedge clk);
        redirect_valid = 1'b0;
        chk("same_ack_req", 32'(imem_req), 32'd1);
        chk("same_ack_addr", imem_addr, 32'h0000_0300);
        chk("same_ack_dropped", inst_q, 32'h0000_00EF);
        imem_ack = 1'b1; imem_rdata = 32'h0000_0063;
        @(negedge clk);
        imem_ack = 1'b0;
        @(negedge clk);
        chk("same_ack_issue_pc", dec_pc, 32'h0000_0300);
        chk("same_ack_issue_fmt", 32'(imm_fmt), 32'd3);

        // PC wrap from 32'hFFFF_FFFC to 0.
        do_reset();
        clear_log();
        force_redir = 1'b1; force_pc = 32'hFFFF_FFFF;
        run_issues(3);
        chk("wrap_pc_top", iss_pc_q[1], 32'hFFFF_FFFC);
        chk("wrap_pc_zero", iss_pc_q[2], 32'h0);

        // Reset while a fetch is outstanding, with ack held through reset and IDLE.
        @(negedge clk);
        chk("midrst_pre_req", 32'(imem_req), 32'd1);
        dec_ready = 1'b0; reset_n = 1'b0; imem_ack = 1'b1; imem_rdata = 32'h0000_00EF;
        @(negedge clk);
        chk("midrst_req", 32'(imem_req), 32'd0);
        chk("midrst_addr", imem_addr, 32'h0);
        reset_n = 1'b1;
        @(negedge clk);
        chk("midrst_refetch", 32'(imem_req), 32'd1);
        chk("midrst_ack_ignored", inst_q, 32'h0);
        chk("midrst_dec_pc", dec_pc, 32'h0);
        imem_ack = 1'b0;
        model_init();
        run_issues(1);

        // Randomized phase.
        do_reset();
        rand_lat = 1'b1; rand_ready = 1'b1; rand_redir = 1'b1; rand_words = 1'b1;
        model_init();
        run_issues(300);
        rand_lat = 1'b0; rand_ready = 1'b0; rand_redir = 1'b0; rand_words = 1'b0;

        // All-ones word: invalid opcode.
        do_reset();
        @(negedge clk);
        chk("ill_req", 32'(imem_req), 32'd1);
        imem_ack = 1'b1; imem_rdata = 32'hFFFF_FFFF;
        @(negedge clk);
        imem_ack = 1'b0;
        @(negedge clk);
`ifdef FETCH_ILLEGAL_TRAP_EN
        chk("ill_flag", 32'(illegal), 32'd1);
        chk("ill_fmt", 32'(imm_fmt), 32'd0);
        for (int i = 0; i < 5; i++) begin
            chk("halt_no_valid", 32'(dec_valid), 32'd0);
            chk("halt_no_req", 32'(imem_req), 32'd0);
            chk("halt_sticky", 32'(illegal), 32'd1);
            @(negedge clk);
        end
        redirect_valid = 1'b1; redirect_pc = 32'h0000_0040;
        @(negedge clk);
        redirect_valid = 1'b0;
        chk("halt_exit_illegal", 32'(illegal), 32'd0);
        chk("halt_exit_req", 32'(imem_req), 32'd1);
        chk("halt_exit_addr", imem_addr, 32'h0000_0040);
`else
        chk("ill_as_r_valid", 32'(dec_valid), 32'd1);
        chk("ill_as_r_fmt", 32'(imm_fmt), 32'd0);
        chk("ill_as_r_flag", 32'(illegal), 32'd0);
        chk("ill_as_r_inst", inst_q, 32'hFFFF_FFFF);
        dec_ready = 1'b1;
        @(negedge clk);
        dec_ready = 1'b0;
        chk("ill_next_req", 32'(imem_req), 32'd1);
        chk("ill_next_addr", imem_addr, 32'h4);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
